// File: rtl/axis_fifo_if.sv
// -----------------------------------------------------------------------------
// axis_fifo_if
// AXI-Stream beat bundle shared by both sides of axis_fifo.
//
// Parameters
//   width   TData width in bits; data is declared [0:width-1]
//
// Signals
//   TData   beat data            (master -> slave)
//   TValid  beat valid           (master -> slave)
//   TLast   last beat of packet  (master -> slave)
//   TReady  slave can accept     (slave  -> master)
//
// Modports
//   master  drives TData/TValid/TLast, samples TReady
//   slave   samples TData/TValid/TLast, drives TReady
// -----------------------------------------------------------------------------
interface axis_fifo_if #(
    parameter int width = 8
) ();

    logic [0:width-1] TData;
    logic             TValid;
    logic             TLast;
    logic             TReady;

    modport master (
        output TData,
        output TValid,
        output TLast,
        input  TReady
    );

    modport slave (
        input  TData,
        input  TValid,
        input  TLast,
        output TReady
    );

endinterface : axis_fifo_if

// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo
// Single-clock AXI-Stream FIFO with first-word-fall-through output. Buffers up
// to `depth` beats of {TLast, TData} between an upstream master and a
// downstream slave. A beat written at edge N is visible at the output after
// edge N; there is no bypass path when the FIFO is empty.
//
// Parameters
//   depth   number of storage entries (>= 2, need not be a power of two)
//   width   TData width in bits
//
// Ports
//   CLK      in   clock, all logic on the rising edge
//   Reset    in   synchronous active-high reset / flush (contents not cleared)
//   s_axis   slave modport  : upstream beats in (S_TData/S_TValid/S_TLast/S_TReady)
//   m_axis   master modport : head beat out     (M_TData/M_TValid/M_TLast/M_TReady)
//   isEmpty  out  no entries stored
//   isFull   out  depth entries stored
//
// Configuration
//   FIFO_PACKET_MODE_EN  when defined, the head beat is only offered once at
//                        least one complete packet (a stored TLast beat) is
//                        present, or the FIFO is full (deadlock release).
//                        When undefined the FIFO is plain FWFT.
// -----------------------------------------------------------------------------
module axis_fifo #(
    parameter int depth = 8,
    parameter int width = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    axis_fifo_if.slave  s_axis,
    axis_fifo_if.master m_axis,
    output logic        isEmpty,
    output logic        isFull
);

    localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int CNT_W = $clog2(depth + 1);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(depth - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(depth);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PTR_ZERO;
        end else begin
            nxt = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Counter update from independent increment/decrement strobes.
    function automatic logic [CNT_W-1:0] upd_cnt(input logic [CNT_W-1:0] cnt,
                                                 input logic              inc,
                                                 input logic              dec);
        logic [CNT_W-1:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + CNT_ONE;
            2'b01:   nxt = cnt - CNT_ONE;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

    // Entry layout: bit 0 is TLast, bits 1..width are TData.
    logic [0:width]   mem_r [0:depth-1];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             is_full_s;
    logic             is_empty_s;
    logic             s_ready_s;
    logic             m_valid_s;
    logic             wr_fire_s;
    logic             rd_fire_s;
    logic [0:width]   rd_entry_s;

`ifdef FIFO_PACKET_MODE_EN
    logic [CNT_W-1:0] pkt_cnt_r;
    logic             pkt_ready_s;
    logic             rd_last_s;
`endif

    // Status flags and handshake qualifiers, all derived from registered count.
    always_comb begin
        is_full_s  = (count_r == CNT_FULL);
        is_empty_s = (count_r == CNT_ZERO);
        s_ready_s  = !is_full_s;
`ifdef FIFO_PACKET_MODE_EN
        // Releasing on full keeps a packet larger than the FIFO from stalling forever.
        pkt_ready_s = (pkt_cnt_r != CNT_ZERO) || is_full_s;
        m_valid_s   = !is_empty_s && pkt_ready_s;
`else
        m_valid_s  = !is_empty_s;
`endif
        wr_fire_s  = s_axis.TValid && s_ready_s;
        rd_fire_s  = m_valid_s && m_axis.TReady;
    end

    // Head entry read out combinationally (first-word-fall-through).
    always_comb begin
        rd_entry_s = mem_r[rd_ptr_r];
`ifdef FIFO_PACKET_MODE_EN
        rd_last_s  = rd_entry_s[0];
`endif
    end

    // Port drivers.
    always_comb begin
        s_axis.TReady = s_ready_s;
        m_axis.TValid = m_valid_s;
        m_axis.TLast  = rd_entry_s[0];
        m_axis.TData  = rd_entry_s[1:width];
        isEmpty       = is_empty_s;
        isFull        = is_full_s;
    end

    // Storage array; not reset, a flush only moves the pointers.
    always_ff @(posedge CLK) begin
        if (!Reset && wr_fire_s) begin
            mem_r[wr_ptr_r] <= {s_axis.TLast, s_axis.TData};
        end
    end

    // Pointers and occupancy; reset overrides any handshake in the same cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_fire_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= upd_cnt(count_r, wr_fire_s, rd_fire_s);
        end
    end

`ifdef FIFO_PACKET_MODE_EN
    // Number of complete packets held: stored beats carrying TLast.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pkt_cnt_r <= CNT_ZERO;
        end else begin
            pkt_cnt_r <= upd_cnt(pkt_cnt_r,
                                 wr_fire_s && s_axis.TLast,
                                 rd_fire_s && rd_last_s);
        end
    end
`endif

endmodule : axis_fifo

// File: tb/tb_axis_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo
// Self-checking bench for axis_fifo. A queue of {TLast, TData} beats models the
// FIFO contents; every cycle the DUT outputs are compared against the queue on
// the falling edge. Directed sequences pin the model with literal values, then
// a randomized phase exercises full/empty/wrap/reset interleavings.
// -----------------------------------------------------------------------------
module tb_axis_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic CLK = 1'b0;
    logic Reset;
    logic is_empty;
    logic is_full;

    always #5 CLK = ~CLK;

    axis_fifo_if #(.width(WIDTH)) s_if ();
    axis_fifo_if #(.width(WIDTH)) m_if ();

    axis_fifo #(
        .depth (DEPTH),
        .width (WIDTH)
    ) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .s_axis  (s_if),
        .m_axis  (m_if),
        .isEmpty (is_empty),
        .isFull  (is_full)
    );

    logic [WIDTH:0] model_q [$];   // {last, data}
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Head beat is offered when anything is stored (plain), or when a whole
    // packet is stored or the FIFO is full (packet mode).
    function automatic bit model_valid();
        if (model_q.size() == 0) return 1'b0;
`ifdef FIFO_PACKET_MODE_EN
        if (model_q.size() == DEPTH) return 1'b1;
        foreach (model_q[i]) if (model_q[i][WIDTH]) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    // Compare all DUT outputs with the model.
    task automatic compare_outputs();
        check("isEmpty", 32'(is_empty), 32'(model_q.size() == 0));
        check("isFull", 32'(is_full), 32'(model_q.size() == DEPTH));
        check("s_tready", 32'(s_if.TReady), 32'(model_q.size() < DEPTH));
        check("m_tvalid", 32'(m_if.TValid), 32'(model_valid()));
        if (model_valid()) begin
            check("m_tdata", 32'(m_if.TData), 32'(model_q[0][WIDTH-1:0]));
            check("m_tlast", 32'(m_if.TLast), 32'(model_q[0][WIDTH]));
        end
    endtask

    // One clock: model follows the handshake rules at the edge, then compare.
    task automatic cycle();
        bit rd;
        bit wr;
        @(posedge CLK);
        if (Reset) begin
            model_q.delete();
        end else begin
            rd = m_if.TReady && model_valid();
            wr = s_if.TValid && (model_q.size() < DEPTH);
            if (rd) void'(model_q.pop_front());
            if (wr) model_q.push_back({s_if.TLast, s_if.TData});
        end
        @(negedge CLK);
        compare_outputs();
    endtask

    task automatic drive_in(input bit v, input int d, input bit l);
        s_if.TValid = v;
        s_if.TData  = WIDTH'(d);
        s_if.TLast  = l;
    endtask

    initial begin
        Reset       = 1'b1;
        drive_in(1'b0, 0, 1'b0);
        m_if.TReady = 1'b0;

        // Reset state.
        cycle();
        Reset = 1'b0;
        check("rst_empty", 32'(is_empty), 32'd1);
        check("rst_full", 32'(is_full), 32'd0);
        check("rst_sready", 32'(s_if.TReady), 32'd1);
        check("rst_mvalid", 32'(m_if.TValid), 32'd0);

        // Fill with 8..1, TLast on the last one.
        for (int i = 0; i < DEPTH; i++) begin
            drive_in(1'b1, 8 - i, i == DEPTH - 1);
            cycle();
        end
        check("fill_full", 32'(is_full), 32'd1);
        check("fill_sready", 32'(s_if.TReady), 32'd0);
        check("fill_head", 32'(m_if.TData), 32'd8);

        // Ninth beat refused.
        drive_in(1'b1, 99, 1'b0);
        cycle();
        check("refuse_size", 32'(model_q.size()), 32'd8);
        check("refuse_head", 32'(m_if.TData), 32'd8);

        // Drain in order.
        drive_in(1'b0, 0, 1'b0);
        m_if.TReady = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_data", 32'(m_if.TData), 32'(8 - i));
            check("drain_last", 32'(m_if.TLast), 32'(i == DEPTH - 1));
            cycle();
        end
        check("drain_empty", 32'(is_empty), 32'd1);
        check("drain_mvalid", 32'(m_if.TValid), 32'd0);

        // Half full, then simultaneous write+read across pointer wrap.
        m_if.TReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, 16 + i, 1'b1);
            cycle();
        end
        m_if.TReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stream_head", 32'(m_if.TData), 32'(16 + i));
            drive_in(1'b1, 20 + i, 1'b1);
            cycle();
        end
        check("stream_size", 32'(model_q.size()), 32'd4);
        check("stream_head_end", 32'(m_if.TData), 32'd26);

        // Flush mid-transfer.
        Reset = 1'b1;
        drive_in(1'b0, 0, 1'b0);
        cycle();
        Reset = 1'b0;
        m_if.TReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, 40 + i, i == 2);
            cycle();
        end
        Reset = 1'b1;
        drive_in(1'b1, 77, 1'b1);
        cycle();
        Reset = 1'b0;
        check("flush_empty", 32'(is_empty), 32'd1);
        check("flush_mvalid", 32'(m_if.TValid), 32'd0);
        drive_in(1'b1, 85, 1'b1);
        cycle();
        drive_in(1'b0, 0, 1'b0);
        check("flush_new_head", 32'(m_if.TData), 32'd85);
        check("flush_new_last", 32'(m_if.TLast), 32'd1);
        m_if.TReady = 1'b1;
        cycle();
        check("flush_drained", 32'(is_empty), 32'd1);

        // Randomized traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 4000; i++) begin
            int phase;
            phase = (i / 250) % 3;
            Reset = ($urandom_range(0, 299) == 0);
            drive_in($urandom_range(0, 99) < (phase == 0 ? 85 : (phase == 1 ? 30 : 60)),
                     int'($urandom_range(0, 255)),
                     $urandom_range(0, 3) == 0);
            m_if.TReady = $urandom_range(0, 99) < (phase == 0 ? 30 : (phase == 1 ? 85 : 60));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_axis_fifo
